// File: rtl/arb_requester_if.sv
// Command, arbiter and bus signals of one requester port.
// master = requester agent, slave = command source / arbiter / bus side.
interface arb_requester_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              req;
  logic              gnt;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_last;
  logic              busy;
  logic              grant_lost;
  logic              timeout_err;

  modport master (
    input  cmd_valid, cmd_len, cmd_data, gnt,
    output cmd_ready, req, bus_valid, bus_data, bus_last, busy, grant_lost, timeout_err
  );
  modport slave (
    output cmd_valid, cmd_len, cmd_data, gnt,
    input  cmd_ready, req, bus_valid, bus_data, bus_last, busy, grant_lost, timeout_err
  );
endinterface

// File: rtl/arb_requester.sv
// Requester agent: queues burst commands, requests the arbiter, drives bursts while granted.
// Optional REQ_TIMEOUT_EN bounds the grant wait to TIMEOUT cycles.
module arb_requester #(
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  arb_requester_if.master rq
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          full, empty, push, pop;
  cmd_t          head;

  state_t            state;
  logic              req_q, bus_valid_q, bus_last_q, grant_lost_q, busy_q, busy_nxt;
  logic [DATA_W-1:0] bus_data_q;
  logic [LEN_W-1:0]  cnt;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = rq.cmd_valid && !full;
  assign head  = mem[rd_ptr];
  // Head leaves on the last beat or when the grant is yanked mid-burst.
  assign pop   = (state == XFER) && ((cnt == '0) || !rq.gnt);

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (!push && pop) count_nxt = count - 1'b1;
  end

  // Idle next cycle only from IDLE-with-nothing-queued or REL seeing the grant gone.
  always_comb begin
    busy_nxt = (count_nxt != '0) ||
               !(((state == IDLE) && empty) || ((state == REL) && !rq.gnt));
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_t'{len: rq.cmd_len, data: rq.cmd_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      busy_q <= busy_nxt;
    end
  end

`ifdef REQ_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT + 1);
  logic [WCW-1:0] wcnt;
  logic           timeout_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_q        <= 1'b0;
      bus_valid_q  <= 1'b0;
      bus_data_q   <= '0;
      bus_last_q   <= 1'b0;
      grant_lost_q <= 1'b0;
      cnt          <= '0;
`ifdef REQ_TIMEOUT_EN
      wcnt          <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      grant_lost_q <= 1'b0;
`ifdef REQ_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
      case (state)
        IDLE: if (!empty) begin
          state <= REQ;
          req_q <= 1'b1;
`ifdef REQ_TIMEOUT_EN
          wcnt  <= '0;
`endif
        end
        REQ: if (rq.gnt) begin
          state       <= XFER;
          bus_valid_q <= 1'b1;
          bus_data_q  <= head.data;
          cnt         <= head.len;
          bus_last_q  <= (head.len == '0);
        end
`ifdef REQ_TIMEOUT_EN
        // Give up on this grant round; the command stays queued and is retried.
        else if (wcnt == WCW'(TIMEOUT - 1)) begin
          state         <= REL;
          req_q         <= 1'b0;
          timeout_err_q <= 1'b1;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
`endif
        XFER: begin
          if (cnt == '0) begin
            state       <= REL;
            req_q       <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_last_q  <= 1'b0;
          end else if (!rq.gnt) begin
            state        <= REL;
            req_q        <= 1'b0;
            bus_valid_q  <= 1'b0;
            bus_last_q   <= 1'b0;
            grant_lost_q <= 1'b1;
          end else begin
            bus_data_q <= bus_data_q + 1'b1;
            cnt        <= cnt - 1'b1;
            bus_last_q <= (cnt == LEN_W'(1));
          end
        end
        REL: if (!rq.gnt) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rq.cmd_ready  = !full;
  assign rq.req        = req_q;
  assign rq.bus_valid  = bus_valid_q;
  assign rq.bus_data   = bus_data_q;
  assign rq.bus_last   = bus_last_q;
  assign rq.busy       = busy_q;
  assign rq.grant_lost = grant_lost_q;
`ifdef REQ_TIMEOUT_EN
  assign rq.timeout_err = timeout_err_q;
`else
  assign rq.timeout_err = 1'b0;
`endif
endmodule
